bldc_six_step_ctrl: RTL

Parametrised six-step BLDC commutation controller, successor to the fixed 4-bit-duty MAIN block. Synchronises and filters the three hall inputs and decodes the commutation sector. Chops the active high-side switch with a counter-compare PWM of configurable width, with per-leg dead-time insertion. Adds direction, brake, enable and invalid-hall fault handling. Drives the six gate outputs A/AA, B/BB, C/CC of the inverter bridge.

---
 rtl/bldc_pkg.sv | 56 +++++
 rtl/bldc_deadtime_leg.sv | 63 ++++++
 rtl/bldc_six_step_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/bldc_pkg.sv
// Shared types and helpers for the six-step BLDC commutation controller:
// per-leg request encoding, hall code constants and the commutation table.
package bldc_pkg;

  // What a half-bridge leg is asked to do this cycle.
  typedef enum logic [1:0] {
    LEG_OFF = 2'd0,
    LEG_HI  = 2'd1,
    LEG_LO  = 2'd2
  } leg_req_e;

  // Requests for the three legs A, B, C.
  typedef struct packed {
    leg_req_e a;
    leg_req_e b;
    leg_req_e c;
  } leg_set_t;

  // Hall codes, written as {H3,H2,H1}.
  localparam logic [2:0] HALL_101 = 3'b101;
  localparam logic [2:0] HALL_100 = 3'b100;
  localparam logic [2:0] HALL_110 = 3'b110;
  localparam logic [2:0] HALL_010 = 3'b010;
  localparam logic [2:0] HALL_011 = 3'b011;
  localparam logic [2:0] HALL_001 = 3'b001;
  localparam logic [2:0] HALL_BAD_000 = 3'b000;
  localparam logic [2:0] HALL_BAD_111 = 3'b111;

  // True for the two codes a healthy sensor set never produces.
  function automatic logic hall_invalid(input logic [2:0] code);
    return (code == HALL_BAD_000) || (code == HALL_BAD_111);
  endfunction

  // Hall code + direction -> leg requests. In each sector one leg is the
  // PWM high side (LEG_HI), one is the static low side (LEG_LO) and the third
  // floats. Reverse direction swaps the roles of the two driven phases.
  function automatic leg_set_t commutate(input logic [2:0] code, input logic dir);
    leg_set_t s;
    leg_req_e fwd_hi;
    leg_req_e fwd_lo;
    s = '{a: LEG_OFF, b: LEG_OFF, c: LEG_OFF};
    fwd_hi = dir ? LEG_LO : LEG_HI;
    fwd_lo = dir ? LEG_HI : LEG_LO;
    case (code)
      HALL_101: begin s.a = fwd_hi; s.b = fwd_lo; end
      HALL_100: begin s.a = fwd_hi; s.c = fwd_lo; end
      HALL_110: begin s.b = fwd_hi; s.c = fwd_lo; end
      HALL_010: begin s.b = fwd_hi; s.a = fwd_lo; end
      HALL_011: begin s.c = fwd_hi; s.a = fwd_lo; end
      HALL_001: begin s.c = fwd_hi; s.b = fwd_lo; end
      default:  s = '{a: LEG_OFF, b: LEG_OFF, c: LEG_OFF};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bldc_deadtime_leg.sv
// One half-bridge leg with dead-time insertion. Turn-off follows the request
// with one register of delay; turn-on of a side waits until the opposite side
// has been off for DEAD_CYC cycles. Each side keeps a saturating off-counter
// that is held at zero while that side is on.
module bldc_deadtime_leg #(
  parameter int DEAD_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic hi_req,
  input  logic lo_req,
  output logic hi_out,
  output logic lo_out
);

  localparam logic [7:0] DEAD = 8'(DEAD_CYC);

  logic       hi_q, hi_d;
  logic       lo_q, lo_d;
  logic [7:0] hi_off_q, hi_off_d;
  logic [7:0] lo_off_q, lo_off_d;

  // Gate decisions and off-time bookkeeping. An off-counter >= 1 implies
  // that side is currently off, so the dead-time test alone is sufficient
  // to keep both switches from ever being on together.
  always_comb begin
    hi_d = hi_req && !lo_req && (lo_off_q >= DEAD);
    lo_d = lo_req && !hi_req && (hi_off_q >= DEAD);

    hi_off_d = hi_off_q;
    if (hi_d) begin
      hi_off_d = 8'd0;
    end else if (hi_off_q < DEAD) begin
      hi_off_d = hi_off_q + 8'd1;
    end

    lo_off_d = lo_off_q;
    if (lo_d) begin
      lo_off_d = 8'd0;
    end else if (lo_off_q < DEAD) begin
      lo_off_d = lo_off_q + 8'd1;
    end
  end

  // Registered gate drives and off-counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q     <= 1'b0;
      lo_q     <= 1'b0;
      hi_off_q <= 8'd0;
      lo_off_q <= 8'd0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_off_q <= hi_off_d;
      lo_off_q <= lo_off_d;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: rtl/bldc_six_step_ctrl.sv
// Six-step BLDC commutation controller: hall synchroniser and glitch filter,
// counter-compare PWM on the active high side with period-aligned duty
// updates, invalid-hall fault latch, brake/enable handling, and three
// dead-time legs driving the inverter gates.
module bldc_six_step_ctrl
  import bldc_pkg::*;
#(
  parameter int PWM_W    = 8,
  parameter int DEAD_CYC = 4,
  parameter int FILT_LEN = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             DIR,
  input  logic             BRAKE,
  input  logic [PWM_W-1:0] DUTY,
  input  logic             H1,
  input  logic             H2,
  input  logic             H3,
  output logic             A_OUT,
  output logic             B_OUT,
  output logic             C_OUT,
  output logic             AA_OUT,
  output logic             BB_OUT,
  output logic             CC_OUT,
  output logic             FAULT,
  output logic [2:0]       SECTOR,
  output logic             PWM_SYNC
);

  // Last counter value of a period; the period is 2^PWM_W-1 cycles.
  localparam logic [PWM_W-1:0] CNT_MAX = {{(PWM_W-1){1'b1}}, 1'b0};
  localparam logic [3:0]       FILT    = 4'(FILT_LEN);

  // Hall path state.
  logic [2:0] hs1_q, hs2_q;
  logic [1:0] vld_q;
  logic [2:0] cand_q, cand_d;
  logic [3:0] fcnt_q, fcnt_d;
  logic [2:0] sector_q, sector_d;
  logic       fault_q, fault_d;
  logic       accept;

  // PWM state.
  logic [PWM_W-1:0] cnt_q, cnt_d;
  logic [PWM_W-1:0] shadow_q, shadow_d;
  logic             sync_q, sync_d;
  logic             pwm_on;

  // Leg requests, index 0 = A, 1 = B, 2 = C.
  leg_set_t   legs;
  logic [2:0] hi_req, lo_req;
  logic [2:0] hi_out, lo_out;

  // Two-flop synchroniser; vld_q marks when it holds real pin samples so
  // the reset value of the flops is never accepted as a hall code.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hs1_q <= 3'b000;
      hs2_q <= 3'b000;
      vld_q <= 2'b00;
    end else begin
      hs1_q <= {H3, H2, H1};
      hs2_q <= hs1_q;
      vld_q <= {vld_q[0], 1'b1};
    end
  end

  // Glitch filter: count consecutive equal samples, accept at FILT_LEN.
  // Invalid accepted codes latch the fault while enabled; EN=0 clears it.
  always_comb begin
    cand_d   = cand_q;
    fcnt_d   = fcnt_q;
    sector_d = sector_q;
    accept   = 1'b0;
    if (!vld_q[1]) begin
      fcnt_d = 4'd0;
    end else if ((fcnt_q == 4'd0) || (hs2_q != cand_q)) begin
      cand_d = hs2_q;
      fcnt_d = 4'd1;
    end else if (fcnt_q != FILT) begin
      fcnt_d = fcnt_q + 4'd1;
    end
    if (fcnt_d == FILT) begin
      accept   = 1'b1;
      sector_d = cand_d;
    end
    fault_d = EN ? (fault_q | (accept & hall_invalid(cand_d))) : 1'b0;
  end

  // Hall filter, accepted sector and fault registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cand_q   <= 3'b000;
      fcnt_q   <= 4'd0;
      sector_q <= 3'b000;
      fault_q  <= 1'b0;
    end else begin
      cand_q   <= cand_d;
      fcnt_q   <= fcnt_d;
      sector_q <= sector_d;
      fault_q  <= fault_d;
    end
  end

  // PWM counter with shadowed duty; the shadow loads on the last count so a
  // new duty always starts on a period boundary.
  always_comb begin
    if (!EN) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    shadow_d = (cnt_q == CNT_MAX) ? DUTY : shadow_q;
    sync_d   = EN && (cnt_d == '0);
    pwm_on   = (cnt_q < shadow_q);
  end

  // PWM counter, duty shadow and sync pulse registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      sync_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      sync_q   <= sync_d;
    end
  end

  // Leg requests in priority order: fault, disable, brake, commutation.
  always_comb begin
    legs = commutate(sector_q, DIR);
    if (fault_q || !EN) begin
      legs = '{a: LEG_OFF, b: LEG_OFF, c: LEG_OFF};
    end else if (BRAKE) begin
      legs = '{a: LEG_LO, b: LEG_LO, c: LEG_LO};
    end
    hi_req[0] = (legs.a == LEG_HI) && pwm_on;
    hi_req[1] = (legs.b == LEG_HI) && pwm_on;
    hi_req[2] = (legs.c == LEG_HI) && pwm_on;
    lo_req[0] = (legs.a == LEG_LO);
    lo_req[1] = (legs.b == LEG_LO);
    lo_req[2] = (legs.c == LEG_LO);
  end

  bldc_deadtime_leg #(.DEAD_CYC(DEAD_CYC)) u_leg_a (
    .clk(CLK), .rst(RST), .hi_req(hi_req[0]), .lo_req(lo_req[0]),
    .hi_out(hi_out[0]), .lo_out(lo_out[0])
  );

  bldc_deadtime_leg #(.DEAD_CYC(DEAD_CYC)) u_leg_b (
    .clk(CLK), .rst(RST), .hi_req(hi_req[1]), .lo_req(lo_req[1]),
    .hi_out(hi_out[1]), .lo_out(lo_out[1])
  );

  bldc_deadtime_leg #(.DEAD_CYC(DEAD_CYC)) u_leg_c (
    .clk(CLK), .rst(RST), .hi_req(hi_req[2]), .lo_req(lo_req[2]),
    .hi_out(hi_out[2]), .lo_out(lo_out[2])
  );

  assign A_OUT    = hi_out[0];
  assign B_OUT    = hi_out[1];
  assign C_OUT    = hi_out[2];
  assign AA_OUT   = lo_out[0];
  assign BB_OUT   = lo_out[1];
  assign CC_OUT   = lo_out[2];
  assign FAULT    = fault_q;
  assign SECTOR   = sector_q;
  assign PWM_SYNC = sync_q;

endmodule
